sv_streamer: RTL and testbench

//  Upstream sequencer for the SVM test-sum stage. On a start pulse, reads one test vector and
//  NUM_SV support vectors plus their alphas from synchronous RAMs and streams them element by

---
 rtl/svm_pkg.sv | 21 ++
 rtl/alpha_delay.sv | 72 +++++++
 rtl/sv_streamer.sv | 198 +++++++++++++++++++
 tb/tb_sv_streamer.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/svm_pkg.sv
// Shared types and helpers for the SVM streaming datapath.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package svm_pkg;

   localparam int DATA_W_DEF = 32;

   typedef logic signed [DATA_W_DEF-1:0] data_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FETCH  = 2'd1,
      STREAM = 2'd2
   } streamer_state_t;

   // Address width that never collapses to zero bits for single-entry memories.
   function automatic int clog2_min1(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/alpha_delay.sv
// Delays a load-qualified word by ALPHA_DLY cycles and holds the last value delivered.
// Latency: ALPHA_DLY cycles from load to dout (0 = combinational pass-through).
// Backpressure: none; every load is delivered.
//
// Ports: clk, rst_n (async active-low), load (capture din this cycle), din, dout (held).
module alpha_delay #(
   parameter int DATA_W    = 32,
   parameter int ALPHA_DLY = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic [DATA_W-1:0] din,
   output logic [DATA_W-1:0] dout
);

   logic              tail_vld;
   logic [DATA_W-1:0] tail_dat;
   logic [DATA_W-1:0] hold_q;
   logic [DATA_W-1:0] hold_d;

   generate
      if (ALPHA_DLY == 0) begin : g_pass
         assign tail_vld = load;
         assign tail_dat = din;
      end else begin : g_dly
         // Each stage carries a valid tag so only real loads update the output.
         logic              vld_q [ALPHA_DLY];
         logic              vld_d [ALPHA_DLY];
         logic [DATA_W-1:0] dat_q [ALPHA_DLY];
         logic [DATA_W-1:0] dat_d [ALPHA_DLY];

         always_comb begin
            vld_d[0] = load;
            dat_d[0] = din;
            for (int i = 1; i < ALPHA_DLY; i++) begin
               vld_d[i] = vld_q[i-1];
               dat_d[i] = dat_q[i-1];
            end
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               for (int i = 0; i < ALPHA_DLY; i++) begin
                  vld_q[i] <= 1'b0;
                  dat_q[i] <= '0;
               end
            end else begin
               for (int i = 0; i < ALPHA_DLY; i++) begin
                  vld_q[i] <= vld_d[i];
                  dat_q[i] <= dat_d[i];
               end
            end
         end

         assign tail_vld = vld_q[ALPHA_DLY-1];
         assign tail_dat = dat_q[ALPHA_DLY-1];
      end
   endgenerate

   assign dout   = tail_vld ? tail_dat : hold_q;
   assign hold_d = dout;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_q <= '0;
      end else begin
         hold_q <= hold_d;
      end
   end

endmodule

// File: rtl/sv_streamer.sv
// Sequences one test vector and NUM_SV support vectors (plus alphas) out of sync RAMs per start.
// Latency: busy 1 cycle after start, first element 2 cycles after start, DIM*NUM_SV gapless beats.
// Backpressure: none; downstream must accept one element per cycle, start ignored while busy.
//
// Ports: clk, rst_n (async active-low); start/busy/done handshake; test_/sv_/alpha_ addr+rdata
// to 1-cycle-latency RAMs; test/support_vector/alpha data out with in_valid, in_start, in_end,
// vector_start, vector_end framing. Optional macro SV_STREAM_STATS_EN adds class_count and
// stream_cycles outputs.
module sv_streamer
   import svm_pkg::*;
#(
   parameter int DIM       = 16,
   parameter int NUM_SV    = 64,
   parameter int DATA_W    = DATA_W_DEF,
   parameter int ALPHA_DLY = 4,
   localparam int TA_W     = clog2_min1(DIM),
   localparam int SA_W     = clog2_min1(DIM * NUM_SV),
   localparam int AA_W     = clog2_min1(NUM_SV)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start,
   output logic                     busy,
   output logic                     done,
   output logic [TA_W-1:0]          test_addr,
   input  logic [DATA_W-1:0]        test_rdata,
   output logic [SA_W-1:0]          sv_addr,
   input  logic [DATA_W-1:0]        sv_rdata,
   output logic [AA_W-1:0]          alpha_addr,
   input  logic [DATA_W-1:0]        alpha_rdata,
   output logic signed [DATA_W-1:0] test,
   output logic signed [DATA_W-1:0] support_vector,
   output logic signed [DATA_W-1:0] alpha,
   output logic                     in_valid,
   output logic                     in_start,
   output logic                     in_end,
   output logic                     vector_start,
   output logic                     vector_end
`ifdef SV_STREAM_STATS_EN
   ,
   output logic [31:0]              class_count,
   output logic [31:0]              stream_cycles
`endif
);

   streamer_state_t state_q, state_d;
   logic [TA_W-1:0] feat_q, feat_d;
   logic [AA_W-1:0] sv_q, sv_d;
   logic [SA_W-1:0] sv_base_q, sv_base_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            in_valid_q, in_valid_d;
   logic            in_start_q, in_start_d;
   logic            in_end_q, in_end_d;
   logic            vector_start_q, vector_start_d;
   logic            vector_end_q, vector_end_d;

   logic            issue;
   logic            last_feat;
   logic            last_sv;

   // An address is issued in FETCH and every STREAM cycle; the framing for that address
   // is registered so it lines up with the RAM data one cycle later.
   assign issue     = (state_q == FETCH) || (state_q == STREAM);
   assign last_feat = (feat_q == TA_W'(DIM - 1));
   assign last_sv   = (sv_q == AA_W'(NUM_SV - 1));

   always_comb begin
      state_d        = state_q;
      feat_d         = feat_q;
      sv_d           = sv_q;
      sv_base_d      = sv_base_q;
      busy_d         = busy_q;
      in_valid_d     = issue;
      in_start_d     = issue && (feat_q == '0) && (sv_q == '0);
      vector_start_d = issue && (feat_q == '0);
      vector_end_d   = issue && last_feat;
      in_end_d       = issue && last_feat && last_sv;
      done_d         = issue && last_feat && last_sv;

      case (state_q)
         IDLE: begin
            // busy_q still high here means this is the done cycle: start is ignored.
            if (start && !busy_q) begin
               state_d = FETCH;
               busy_d  = 1'b1;
            end else begin
               busy_d  = 1'b0;
            end
         end
         FETCH, STREAM: begin
            state_d = STREAM;
            if (last_feat) begin
               feat_d = '0;
               if (last_sv) begin
                  // Final address issued; the done cycle follows in IDLE with busy held.
                  state_d   = IDLE;
                  sv_d      = '0;
                  sv_base_d = '0;
               end else begin
                  sv_d      = sv_q + AA_W'(1);
                  sv_base_d = sv_base_q + SA_W'(DIM);
               end
            end else begin
               feat_d = feat_q + TA_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= IDLE;
         feat_q         <= '0;
         sv_q           <= '0;
         sv_base_q      <= '0;
         busy_q         <= 1'b0;
         done_q         <= 1'b0;
         in_valid_q     <= 1'b0;
         in_start_q     <= 1'b0;
         in_end_q       <= 1'b0;
         vector_start_q <= 1'b0;
         vector_end_q   <= 1'b0;
      end else begin
         state_q        <= state_d;
         feat_q         <= feat_d;
         sv_q           <= sv_d;
         sv_base_q      <= sv_base_d;
         busy_q         <= busy_d;
         done_q         <= done_d;
         in_valid_q     <= in_valid_d;
         in_start_q     <= in_start_d;
         in_end_q       <= in_end_d;
         vector_start_q <= vector_start_d;
         vector_end_q   <= vector_end_d;
      end
   end

   assign test_addr      = feat_q;
   assign sv_addr        = sv_base_q + SA_W'(feat_q);
   assign alpha_addr     = sv_q;

   assign busy           = busy_q;
   assign done           = done_q;
   assign in_valid       = in_valid_q;
   assign in_start       = in_start_q;
   assign in_end         = in_end_q;
   assign vector_start   = vector_start_q;
   assign vector_end     = vector_end_q;
   assign test           = in_valid_q ? test_rdata : '0;
   assign support_vector = in_valid_q ? sv_rdata   : '0;

   // At an SV's last element the alpha RAM output holds that SV's alpha
   // (alpha_addr was still pointing at it one cycle earlier).
   alpha_delay #(
      .DATA_W    (DATA_W),
      .ALPHA_DLY (ALPHA_DLY)
   ) u_alpha_delay (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (in_valid_q && vector_end_q),
      .din   (alpha_rdata),
      .dout  (alpha)
   );

`ifdef SV_STREAM_STATS_EN
   logic [31:0] class_count_q, class_count_d;
   logic [31:0] run_cycles_q, run_cycles_d;
   logic [31:0] stream_cycles_q, stream_cycles_d;

   always_comb begin
      class_count_d   = done_q ? class_count_q + 32'd1 : class_count_q;
      run_cycles_d    = busy_q ? run_cycles_q + 32'd1 : '0;
      // Include the done cycle itself, which is the last busy cycle.
      stream_cycles_d = done_q ? run_cycles_q + 32'd1 : stream_cycles_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         class_count_q   <= '0;
         run_cycles_q    <= '0;
         stream_cycles_q <= '0;
      end else begin
         class_count_q   <= class_count_d;
         run_cycles_q    <= run_cycles_d;
         stream_cycles_q <= stream_cycles_d;
      end
   end

   assign class_count   = class_count_q;
   assign stream_cycles = stream_cycles_q;
`endif

endmodule

// File: tb/tb_sv_streamer.sv
// Bench for sv_streamer: instance A (DIM=4, NUM_SV=2, ALPHA_DLY=4), instance B (DIM=2, NUM_SV=1, ALPHA_DLY=0).
// Latency: n/a.
// Backpressure: n/a.
module tb_sv_streamer;

   localparam int DIM_A   = 4;
   localparam int NSV_A   = 2;
   localparam int N_A     = DIM_A * NSV_A;
   localparam int ALPHA_A = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // ---------------- instance A ----------------
   logic        rst_a, start_a;
   logic        a_busy, a_done, a_iv, a_is, a_ie, a_vs, a_ve;
   logic [1:0]  a_taddr;
   logic [2:0]  a_saddr;
   logic [0:0]  a_aaddr;
   logic [31:0] a_trd, a_srd, a_ard, a_test, a_sv, a_alpha;
   logic [31:0] test_mem_a [DIM_A];
   logic [31:0] sv_mem_a   [N_A];
   logic [31:0] alpha_mem_a[NSV_A];
`ifdef SV_STREAM_STATS_EN
   logic [31:0] a_cc, a_sc;
`endif

   sv_streamer #(.DIM(DIM_A), .NUM_SV(NSV_A), .DATA_W(32), .ALPHA_DLY(ALPHA_A)) u_dut_a (
      .clk(clk), .rst_n(rst_a), .start(start_a), .busy(a_busy), .done(a_done),
      .test_addr(a_taddr), .test_rdata(a_trd), .sv_addr(a_saddr), .sv_rdata(a_srd),
      .alpha_addr(a_aaddr), .alpha_rdata(a_ard), .test(a_test), .support_vector(a_sv),
      .alpha(a_alpha), .in_valid(a_iv), .in_start(a_is), .in_end(a_ie),
      .vector_start(a_vs), .vector_end(a_ve)
`ifdef SV_STREAM_STATS_EN
      , .class_count(a_cc), .stream_cycles(a_sc)
`endif
   );

   always @(posedge clk) begin
      a_trd <= test_mem_a[a_taddr];
      a_srd <= sv_mem_a[a_saddr];
      a_ard <= alpha_mem_a[a_aaddr];
   end

   // ---------------- instance B ----------------
   logic        rst_b, start_b;
   logic        b_busy, b_done, b_iv, b_is, b_ie, b_vs, b_ve;
   logic [0:0]  b_taddr, b_saddr, b_aaddr;
   logic [31:0] b_trd, b_srd, b_ard, b_test, b_sv, b_alpha;
   logic [31:0] test_mem_b [2];
   logic [31:0] sv_mem_b   [2];
   logic [31:0] alpha_mem_b[1];
`ifdef SV_STREAM_STATS_EN
   logic [31:0] b_cc, b_sc;
`endif

   sv_streamer #(.DIM(2), .NUM_SV(1), .DATA_W(32), .ALPHA_DLY(0)) u_dut_b (
      .clk(clk), .rst_n(rst_b), .start(start_b), .busy(b_busy), .done(b_done),
      .test_addr(b_taddr), .test_rdata(b_trd), .sv_addr(b_saddr), .sv_rdata(b_srd),
      .alpha_addr(b_aaddr), .alpha_rdata(b_ard), .test(b_test), .support_vector(b_sv),
      .alpha(b_alpha), .in_valid(b_iv), .in_start(b_is), .in_end(b_ie),
      .vector_start(b_vs), .vector_end(b_ve)
`ifdef SV_STREAM_STATS_EN
      , .class_count(b_cc), .stream_cycles(b_sc)
`endif
   );

   always @(posedge clk) begin
      b_trd <= test_mem_b[b_taddr];
      b_srd <= sv_mem_b[b_saddr];
      b_ard <= alpha_mem_b[b_aaddr];
   end

   // ---------------- reference model for A's stream ----------------
   // Beat k of a run carries feature k%DIM of SV k/DIM; each SV's alpha becomes
   // visible ALPHA_DLY cycles after its last feature and is held afterwards.
   int          cyc = 0;
   int          beat_a = 0;
   int          mf, ms;
   logic [31:0] exp_alpha_a = '0;
   int          aq_due[$];
   logic [31:0] aq_val[$];

   always @(negedge clk) begin
      if (!rst_a) begin
         beat_a      = 0;
         exp_alpha_a = '0;
         aq_due.delete();
         aq_val.delete();
      end else begin
         while (aq_due.size() > 0 && aq_due[0] == cyc) begin
            exp_alpha_a = aq_val[0];
            void'(aq_due.pop_front());
            void'(aq_val.pop_front());
         end
         if (a_iv) begin
            mf = beat_a % DIM_A;
            ms = beat_a / DIM_A;
            chk("a_test", a_test, test_mem_a[mf]);
            chk("a_sv", a_sv, sv_mem_a[ms*DIM_A + mf]);
            chk("a_vector_start", a_vs, mf == 0);
            chk("a_vector_end", a_ve, mf == DIM_A-1);
            chk("a_in_start", a_is, beat_a == 0);
            chk("a_in_end", a_ie, beat_a == N_A-1);
            if (mf == DIM_A-1) begin
               aq_due.push_back(cyc + ALPHA_A);
               aq_val.push_back(alpha_mem_a[ms]);
            end
            beat_a = (beat_a + 1) % N_A;
         end else begin
            chk("a_idle_test", a_test, 0);
            chk("a_idle_sv", a_sv, 0);
            chk("a_idle_framing", {a_is, a_ie, a_vs, a_ve}, 0);
         end
         chk("a_alpha", a_alpha, exp_alpha_a);
      end
      cyc++;
   end

   int cnt_a = 0;

   task automatic fill_a_random();
      for (int i = 0; i < DIM_A; i++) test_mem_a[i] = $urandom;
      for (int i = 0; i < N_A; i++)   sv_mem_a[i]   = $urandom;
      for (int i = 0; i < NSV_A; i++) alpha_mem_a[i] = $urandom;
   endtask

   // One classification on A. t counts cycles after FETCH (t=0); beat k is at t=k+1.
   task automatic run_a(input bit pre, input bit mid_start, input bit done_start,
                        input bit b2b, input int rst_at);
      if (!pre) begin
         @(negedge clk);
         start_a = 1'b1;
      end
      @(negedge clk);
      start_a = 1'b0;
      chk("a_busy_fetch", a_busy, 1);
      chk("a_fetch_no_valid", a_iv, 0);
      for (int t = 1; t <= N_A + 3; t++) begin
         @(negedge clk);
         chk("a_busy", a_busy, t <= N_A);
         chk("a_valid_window", a_iv, t <= N_A);
         chk("a_done", a_done, t == N_A);
         if (t == N_A) cnt_a++;
`ifdef SV_STREAM_STATS_EN
         if (t == N_A + 1) begin
            chk("a_class_count", a_cc, cnt_a);
            chk("a_stream_cycles", a_sc, N_A + 1);
         end
`endif
         if (rst_at > 0 && t == rst_at) begin
            @(posedge clk);
            #2 rst_a = 1'b0;
            #1;
            chk("a_rst_ctrl", {a_busy, a_done, a_iv, a_is, a_ie, a_vs, a_ve}, 0);
            chk("a_rst_test", a_test, 0);
            chk("a_rst_sv", a_sv, 0);
            chk("a_rst_alpha", a_alpha, 0);
            chk("a_rst_addr", {a_taddr, a_saddr, a_aaddr}, 0);
            @(negedge clk);
            @(negedge clk);
            rst_a = 1'b1;
            cnt_a = 0;
            for (int k = 0; k < 4; k++) begin
               @(negedge clk);
               chk("a_abort_quiet", {a_busy, a_done, a_iv}, 0);
            end
            return;
         end
         start_a = (mid_start && t == 4) || (done_start && t == N_A) || (b2b && t == N_A + 1);
         if (b2b && t == N_A + 1) return;
      end
   endtask

   task automatic run_b(input int k);
      for (int i = 0; i < 2; i++) begin
         test_mem_b[i] = $urandom;
         sv_mem_b[i]   = $urandom;
      end
      alpha_mem_b[0] = $urandom;
      @(negedge clk);
      start_b = 1'b1;
      @(negedge clk);
      start_b = 1'b0;
      chk("b_busy_fetch", b_busy, 1);
      chk("b_fetch_no_valid", b_iv, 0);
      @(negedge clk);
      chk("b_beat0_framing", {b_iv, b_is, b_vs, b_ie, b_ve, b_done}, 6'b111000);
      chk("b_beat0_test", b_test, test_mem_b[0]);
      chk("b_beat0_sv", b_sv, sv_mem_b[0]);
      @(negedge clk);
      chk("b_beat1_framing", {b_iv, b_is, b_vs, b_ie, b_ve, b_done}, 6'b100111);
      chk("b_beat1_test", b_test, test_mem_b[1]);
      chk("b_beat1_sv", b_sv, sv_mem_b[1]);
      chk("b_alpha_at_vend", b_alpha, alpha_mem_b[0]);
      @(negedge clk);
      chk("b_after_done", {b_busy, b_iv, b_done}, 0);
      chk("b_alpha_held", b_alpha, alpha_mem_b[0]);
`ifdef SV_STREAM_STATS_EN
      chk("b_class_count", b_cc, k);
      chk("b_stream_cycles", b_sc, 3);
`else
      if (k < 0) chk("b_run_index", k, 0);
`endif
   endtask

   initial begin
      rst_a = 1'b0; rst_b = 1'b0; start_a = 1'b0; start_b = 1'b0;
      for (int i = 0; i < DIM_A; i++) test_mem_a[i] = 100 + i;
      for (int i = 0; i < N_A; i++)   sv_mem_a[i]   = i;
      alpha_mem_a[0] = 5;
      alpha_mem_a[1] = -3;
      test_mem_b[0] = 0; test_mem_b[1] = 0; sv_mem_b[0] = 0; sv_mem_b[1] = 0;
      alpha_mem_b[0] = 0;
      repeat (3) @(negedge clk);
      chk("a_reset_ctrl", {a_busy, a_done, a_iv, a_is, a_ie, a_vs, a_ve}, 0);
      chk("a_reset_data", a_test | a_sv | a_alpha, 0);
      chk("b_reset_ctrl", {b_busy, b_done, b_iv, b_is, b_ie, b_vs, b_ve}, 0);
      rst_a = 1'b1; rst_b = 1'b1;
      repeat (2) @(negedge clk);

      // Directed fill; start mid-stream and in the done cycle are ignored,
      // start one cycle after done launches a new run.
      run_a(1'b0, 1'b1, 1'b1, 1'b1, 0);
      fill_a_random();
      // Back-to-back run aborted by reset during beat 5.
      run_a(1'b1, 1'b0, 1'b0, 1'b0, 5);
      fill_a_random();
      run_a(1'b0, 1'b0, 1'b0, 1'b0, 0);
      for (int r = 0; r < 4; r++) begin
         repeat (ALPHA_A + 2) @(negedge clk);
         fill_a_random();
         run_a(1'b0, r[0], 1'b0, 1'b0, 0);
      end

      for (int k = 1; k <= 3; k++) run_b(k);

      repeat (ALPHA_A + 4) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
